id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register sitting directly downstream of the ID-stage register file.
//  Captures decoded operands (post write-bypass rs1/rs2 data) and control each cycle.
//  Detects load-use hazards against the instruction held in EX, inserts one bubble and
//  back-pressures IF/ID. Honours EX-stage flush and downstream stall, and keeps
//  saturating bubble/flush counters for performance debug.
// PARAMETERS
//  XLEN    32  operand, PC and immediate width
//  CTRL_W  8   opaque control bundle width (ALU op, src sel, etc.), passed through unchanged
//  CNT_W   16  width of the perf counters
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       synchronous reset, active-low
//  id_valid     in   1       ID holds a valid instruction
//  id_pc        in   XLEN    PC of the ID instruction
//  id_rs1Addr   in   5       source 1 index
//  id_rs2Addr   in   5       source 2 index
//  id_usesRs2   in   1       instruction reads rs2 (R/S/B types)
//  id_rdAddr    in   5       destination index
//  id_rs1Data   in   XLEN    bypassed register-file read data 1
//  id_rs2Data   in   XLEN    bypassed register-file read data 2
//  id_imm       in   XLEN    sign-extended immediate
//  id_RegWrite  in   1       writes rd
//  id_MemRead   in   1       is a load
//  id_MemWrite  in   1       is a store
//  id_ctrl      in   CTRL_W  remaining control bundle
//  ex_ready     in   1       EX can accept; 0 = hold register contents
//  flush        in   1       branch/jump redirect from EX; kill ID and EX contents
//  ex_valid     out  1       EX holds a valid instruction
//  ex_pc, ex_rs1Addr, ex_rs2Addr, ex_rdAddr, ex_rs1Data, ex_rs2Data, ex_imm,
//  ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ctrl  out  (widths as id_*)  registered copies
//  id_stall     out  1       hold PC and IF/ID (comb.): hazard | (id_valid & ~ex_ready)
//  bubble_cnt   out  CNT_W   load-use bubbles inserted, saturating
//  flush_cnt    out  CNT_W   cycles with flush asserted, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): ex_valid=0, all ex_* data/control=0, counters=0.
//    Reset mid-hazard or mid-stall discards the held instruction; no pending state survives.
//  - hazard (comb.) = id_valid & ex_valid & ex_MemRead & (ex_rdAddr!=0) &
//    ((ex_rdAddr==id_rs1Addr) | (id_usesRs2 & ex_rdAddr==id_rs2Addr)).
//  - Per-edge update, strict priority:
//    1 flush=1: ex_valid<=0, ex_RegWrite/MemRead/MemWrite<=0; flush_cnt++.
//    2 ex_ready=0: all ex_* hold (no bubble, no load).
//    3 hazard=1: bubble: ex_valid<=0, write-enables<=0, data fields don't-care; bubble_cnt++.
//    4 else: load every id_* into ex_*; ex_valid<=id_valid; write-enables gated by id_valid.
//  - Invalid slots always carry RegWrite=MemRead=MemWrite=0 (no side effects downstream).
//  - Latency 1 cycle ID->EX. A load-use pair costs exactly 1 bubble: after the bubble,
//    EX no longer holds the load, hazard drops, and the dependent instruction advances
//    (result forwarded from MEM by the forwarding unit, outside this block).
//  - id_stall is combinational and is forced to 0 while flush=1 (IF is redirected instead).
//  - Counters saturate at all-ones; no wrap. flush and hazard in the same cycle: flush wins,
//    only flush_cnt increments.
//  - x0 destination never triggers a hazard; rs2 compare ignored when id_usesRs2=0.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with id_valid=1 -> ex_valid=0, ex_RegWrite=0, counters=0.
//  2 Pass-through: id_pc=0x100, rs1Data=0xDEAD, rd=5, RegWrite=1 -> next cycle ex_pc=0x100,
//    ex_rs1Data=0xDEAD, ex_rdAddr=5, ex_valid=1; id_stall=0.
//  3 Load-use: EX holds lw x6; ID add x7,x6,x1 -> id_stall=1 one cycle, bubble (ex_valid=0),
//    bubble_cnt=1; next cycle add enters EX, id_stall=0. Repeat with rd=x0 -> no stall.
//  4 rs2 gating: EX lw x9; ID addi x3,x2,4 with rs2Addr=9, usesRs2=0 -> no hazard, no bubble.
//  5 Downstream stall: ex_ready=0 for 3 cycles -> ex_* unchanged, id_stall=1 each cycle,
//    bubble_cnt unchanged; resumes on ex_ready=1 with the held ID instruction.
//  6 Flush vs hazard same cycle -> ex_valid=0, flush_cnt+1, bubble_cnt unchanged,
//    id_stall=0; drive 2^CNT_W+3 flushes -> flush_cnt stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush/stall handling and perf counters.
// One-cycle ID->EX latency; id_stall holds IF/ID on a load-use hazard or while EX is not ready.
module id_ex_pipe_reg #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [4:0]        id_rs1Addr,
   input  logic [4:0]        id_rs2Addr,
   input  logic              id_usesRs2,
   input  logic [4:0]        id_rdAddr,
   input  logic [XLEN-1:0]   id_rs1Data,
   input  logic [XLEN-1:0]   id_rs2Data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic              id_RegWrite,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              ex_ready,
   input  logic              flush,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [4:0]        ex_rs1Addr,
   output logic [4:0]        ex_rs2Addr,
   output logic [4:0]        ex_rdAddr,
   output logic [XLEN-1:0]   ex_rs1Data,
   output logic [XLEN-1:0]   ex_rs2Data,
   output logic [XLEN-1:0]   ex_imm,
   output logic              ex_RegWrite,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              id_stall,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic hazard;
   logic rs1_match;
   logic rs2_match;

   always_comb begin
      rs1_match = (ex_rdAddr == id_rs1Addr);
      rs2_match = id_usesRs2 & (ex_rdAddr == id_rs2Addr);
      hazard    = id_valid & ex_valid & ex_MemRead & (ex_rdAddr != 5'd0) & (rs1_match | rs2_match);
   end

   // A flush redirects IF, so holding PC/IF-ID would be wrong in that cycle.
   assign id_stall = ~flush & (hazard | (id_valid & ~ex_ready));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1Addr  <= '0;
         ex_rs2Addr  <= '0;
         ex_rdAddr   <= '0;
         ex_rs1Data  <= '0;
         ex_rs2Data  <= '0;
         ex_imm      <= '0;
         ex_RegWrite <= 1'b0;
         ex_MemRead  <= 1'b0;
         ex_MemWrite <= 1'b0;
         ex_ctrl     <= '0;
         bubble_cnt  <= '0;
         flush_cnt   <= '0;
      end else if (flush) begin
         ex_valid    <= 1'b0;
         ex_RegWrite <= 1'b0;
         ex_MemRead  <= 1'b0;
         ex_MemWrite <= 1'b0;
         if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end else if (!ex_ready) begin
         ex_valid <= ex_valid;
      end else if (hazard) begin
         // Data fields keep their old value; only the slot is marked empty.
         ex_valid    <= 1'b0;
         ex_RegWrite <= 1'b0;
         ex_MemRead  <= 1'b0;
         ex_MemWrite <= 1'b0;
         if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
      end else begin
         ex_valid    <= id_valid;
         ex_pc       <= id_pc;
         ex_rs1Addr  <= id_rs1Addr;
         ex_rs2Addr  <= id_rs2Addr;
         ex_rdAddr   <= id_rdAddr;
         ex_rs1Data  <= id_rs1Data;
         ex_rs2Data  <= id_rs2Data;
         ex_imm      <= id_imm;
         ex_RegWrite <= id_RegWrite & id_valid;
         ex_MemRead  <= id_MemRead & id_valid;
         ex_MemWrite <= id_MemWrite & id_valid;
         ex_ctrl     <= id_ctrl;
      end
   end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Table-driven bench for id_ex_pipe_reg plus a flush-counter saturation sequence.
module tb_id_ex_pipe_reg;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [4:0]  id_rs1Addr;
   logic [4:0]  id_rs2Addr;
   logic        id_usesRs2;
   logic [4:0]  id_rdAddr;
   logic [31:0] id_rs1Data;
   logic [31:0] id_rs2Data;
   logic [31:0] id_imm;
   logic        id_RegWrite;
   logic        id_MemRead;
   logic        id_MemWrite;
   logic [7:0]  id_ctrl;
   logic        ex_ready;
   logic        flush;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [4:0]  ex_rs1Addr;
   logic [4:0]  ex_rs2Addr;
   logic [4:0]  ex_rdAddr;
   logic [31:0] ex_rs1Data;
   logic [31:0] ex_rs2Data;
   logic [31:0] ex_imm;
   logic        ex_RegWrite;
   logic        ex_MemRead;
   logic        ex_MemWrite;
   logic [7:0]  ex_ctrl;
   logic        id_stall;
   logic [15:0] bubble_cnt;
   logic [15:0] flush_cnt;

   id_ex_pipe_reg #(.XLEN(32), .CTRL_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1Addr(id_rs1Addr), .id_rs2Addr(id_rs2Addr), .id_usesRs2(id_usesRs2),
      .id_rdAddr(id_rdAddr), .id_rs1Data(id_rs1Data), .id_rs2Data(id_rs2Data),
      .id_imm(id_imm), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
      .id_MemWrite(id_MemWrite), .id_ctrl(id_ctrl), .ex_ready(ex_ready), .flush(flush),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1Addr(ex_rs1Addr), .ex_rs2Addr(ex_rs2Addr),
      .ex_rdAddr(ex_rdAddr), .ex_rs1Data(ex_rs1Data), .ex_rs2Data(ex_rs2Data),
      .ex_imm(ex_imm), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
      .ex_MemWrite(ex_MemWrite), .ex_ctrl(ex_ctrl), .id_stall(id_stall),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // e_stall: -1 = not checked. e_src: -2 = all ex_* zero (reset), -1 = data don't-care,
   // otherwise index of the vector whose ID inputs must now be in EX.
   typedef struct {
      logic        rst_n, vld, u2, rw, mr, mw, rdy, fl;
      logic [31:0] pc, d1;
      logic [4:0]  rs1, rs2, rd;
      int          e_stall, e_vld, e_src, e_bub, e_fl;
   } vec_t;

   vec_t vq[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic void add(input logic r, input logic v, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic [31:0] d1, input logic rw,
                               input logic mr, input logic mw, input logic rdy, input logic fl,
                               input int es, input int ev, input int src, input int eb,
                               input int ef);
      vec_t t;
      t.rst_n = r; t.vld = v; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.u2 = u2; t.rd = rd;
      t.d1 = d1; t.rw = rw; t.mr = mr; t.mw = mw; t.rdy = rdy; t.fl = fl;
      t.e_stall = es; t.e_vld = ev; t.e_src = src; t.e_bub = eb; t.e_fl = ef;
      vq.push_back(t);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst_n       = t.rst_n;
      id_valid    = t.vld;
      id_pc       = t.pc;
      id_rs1Addr  = t.rs1;
      id_rs2Addr  = t.rs2;
      id_usesRs2  = t.u2;
      id_rdAddr   = t.rd;
      id_rs1Data  = t.d1;
      id_rs2Data  = t.d1 ^ 32'hFFFF_0000;
      id_imm      = t.pc + 32'd4;
      id_RegWrite = t.rw;
      id_MemRead  = t.mr;
      id_MemWrite = t.mw;
      id_ctrl     = t.pc[9:2];
      ex_ready    = t.rdy;
      flush       = t.fl;
   endtask

   task automatic check_ex(input int i);
      vec_t t;
      vec_t s;
      t = vq[i];
      if (t.e_src == -2) begin
         chk($sformatf("rst_vld[%0d]", i), {63'd0, ex_valid}, 64'd0);
         chk($sformatf("rst_pc[%0d]", i), {32'd0, ex_pc}, 64'd0);
         chk($sformatf("rst_data[%0d]", i), {ex_rs1Data, ex_rs2Data}, 64'd0);
         chk($sformatf("rst_imm_ctrl[%0d]", i), {24'd0, ex_ctrl, ex_imm}, 64'd0);
         chk($sformatf("rst_addr[%0d]", i), {49'd0, ex_rs1Addr, ex_rs2Addr, ex_rdAddr}, 64'd0);
         chk($sformatf("rst_we[%0d]", i), {61'd0, ex_RegWrite, ex_MemRead, ex_MemWrite}, 64'd0);
      end else begin
         chk($sformatf("ex_valid[%0d]", i), {63'd0, ex_valid}, 64'(t.e_vld));
         if (t.e_vld == 0)
            chk($sformatf("inv_we[%0d]", i), {61'd0, ex_RegWrite, ex_MemRead, ex_MemWrite}, 64'd0);
         if (t.e_src >= 0) begin
            s = vq[t.e_src];
            chk($sformatf("ex_pc[%0d]", i), {32'd0, ex_pc}, {32'd0, s.pc});
            chk($sformatf("ex_data[%0d]", i), {ex_rs1Data, ex_rs2Data},
                {s.d1, s.d1 ^ 32'hFFFF_0000});
            chk($sformatf("ex_imm_ctrl[%0d]", i), {24'd0, ex_ctrl, ex_imm},
                {24'd0, s.pc[9:2], s.pc + 32'd4});
            chk($sformatf("ex_addr[%0d]", i), {49'd0, ex_rs1Addr, ex_rs2Addr, ex_rdAddr},
                {49'd0, s.rs1, s.rs2, s.rd});
            if (t.e_vld != 0)
               chk($sformatf("ex_we[%0d]", i), {61'd0, ex_RegWrite, ex_MemRead, ex_MemWrite},
                   {61'd0, s.rw, s.mr, s.mw});
         end
      end
      chk($sformatf("bubble_cnt[%0d]", i), {48'd0, bubble_cnt}, 64'(t.e_bub));
      chk($sformatf("flush_cnt[%0d]", i), {48'd0, flush_cnt}, 64'(t.e_fl));
   endtask

   initial begin
      //   rst v  pc        rs1 rs2 u  rd  d1            rw mr mw rdy fl  stall vld src bub fl
      add(0, 1, 32'h040,  1,  2, 1,  3, 32'h11,       1, 0, 0, 1, 0,  -1, 0, -2, 0, 0); // 0 reset
      add(0, 1, 32'h040,  1,  2, 1,  3, 32'h11,       1, 0, 0, 1, 0,   0, 0, -2, 0, 0); // 1 reset
      add(1, 1, 32'h100,  1,  2, 1,  5, 32'hDEAD,     1, 0, 0, 1, 0,   0, 1,  2, 0, 0); // 2 pass
      add(1, 1, 32'h104,  2,  0, 0,  6, 32'h200,      1, 1, 0, 1, 0,   0, 1,  3, 0, 0); // 3 lw x6
      add(1, 1, 32'h108,  6,  1, 1,  7, 32'h77,       1, 0, 0, 1, 0,   1, 0, -1, 1, 0); // 4 add x7,x6
      add(1, 1, 32'h108,  6,  1, 1,  7, 32'h77,       1, 0, 0, 1, 0,   0, 1,  5, 1, 0); // 5 advance
      add(1, 1, 32'h10C,  2,  0, 0,  0, 32'h300,      1, 1, 0, 1, 0,   0, 1,  6, 1, 0); // 6 lw x0
      add(1, 1, 32'h110,  0,  0, 1,  8, 32'h88,       1, 0, 0, 1, 0,   0, 1,  7, 1, 0); // 7 use x0
      add(1, 1, 32'h114,  1,  0, 0,  9, 32'h400,      1, 1, 0, 1, 0,   0, 1,  8, 1, 0); // 8 lw x9
      add(1, 1, 32'h118,  2,  9, 0,  3, 32'h99,       1, 0, 0, 1, 0,   0, 1,  9, 1, 0); // 9 addi rs2=9
      add(1, 1, 32'h11C,  1,  0, 0, 10, 32'h500,      1, 1, 0, 1, 0,   0, 1, 10, 1, 0); // 10 lw x10
      add(1, 1, 32'h120,  1, 10, 1,  4, 32'hAA,       1, 0, 0, 1, 0,   1, 0, -1, 2, 0); // 11 rs2 hazard
      add(1, 1, 32'h120,  1, 10, 1,  4, 32'hAA,       1, 0, 0, 1, 0,   0, 1, 12, 2, 0); // 12
      add(1, 1, 32'h130,  3,  4, 1, 11, 32'hBB,       1, 0, 0, 1, 0,   0, 1, 13, 2, 0); // 13
      add(1, 1, 32'h134,  3,  4, 1, 12, 32'h134,      1, 0, 0, 0, 0,   1, 1, 13, 2, 0); // 14 ex_ready=0
      add(1, 1, 32'h134,  3,  4, 1, 12, 32'h134,      1, 0, 0, 0, 0,   1, 1, 13, 2, 0); // 15
      add(1, 1, 32'h134,  3,  4, 1, 12, 32'h134,      1, 0, 0, 0, 0,   1, 1, 13, 2, 0); // 16
      add(1, 1, 32'h134,  3,  4, 1, 12, 32'h134,      1, 0, 0, 1, 0,   0, 1, 17, 2, 0); // 17 resume
      add(1, 1, 32'h138,  1,  0, 0, 13, 32'h600,      1, 1, 0, 1, 0,   0, 1, 18, 2, 0); // 18 lw x13
      add(1, 1, 32'h13C, 13,  0, 0, 14, 32'hCC,       1, 0, 0, 0, 0,   1, 1, 18, 2, 0); // 19 hazard+hold
      add(1, 1, 32'h13C, 13,  0, 0, 14, 32'hCC,       1, 0, 0, 1, 0,   1, 0, -1, 3, 0); // 20 bubble
      add(1, 1, 32'h13C, 13,  0, 0, 14, 32'hCC,       1, 0, 0, 1, 0,   0, 1, 21, 3, 0); // 21
      add(1, 1, 32'h140,  1,  0, 0, 15, 32'h700,      1, 1, 0, 1, 0,   0, 1, 22, 3, 0); // 22 lw x15
      add(1, 1, 32'h144, 15,  0, 0, 16, 32'hDD,       1, 0, 0, 1, 1,   0, 0, -1, 3, 1); // 23 flush+hazard
      add(1, 1, 32'h144, 15,  0, 0, 16, 32'hDD,       1, 0, 0, 1, 0,   0, 1, 24, 3, 1); // 24
      add(1, 1, 32'h148,  2,  3, 1, 17, 32'hEE,       1, 0, 0, 0, 1,   0, 0, -1, 3, 2); // 25 flush, not ready
      add(1, 1, 32'h14C,  2,  3, 1,  0, 32'hF0,       0, 0, 1, 1, 0,   0, 1, 26, 3, 2); // 26 store
      add(1, 1, 32'h150,  1,  0, 0, 18, 32'h800,      1, 1, 0, 1, 0,   0, 1, 27, 3, 2); // 27 lw x18
      add(0, 1, 32'h154, 18,  0, 0, 19, 32'h155,      1, 0, 0, 1, 0,   1, 0, -2, 0, 0); // 28 reset mid-hazard
      add(1, 1, 32'h154, 18,  0, 0, 19, 32'h155,      1, 0, 0, 1, 0,   0, 1, 29, 0, 0); // 29
      add(1, 0, 32'h158,  1,  2, 1, 20, 32'h158,      1, 1, 1, 1, 0,   0, 0, -1, 0, 0); // 30 invalid slot
      add(1, 0, 32'h15C,  1,  2, 1, 21, 32'h15C,      1, 1, 1, 0, 0,   0, 0, -1, 0, 0); // 31

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i]);
         #1;
         if (vq[i].e_stall >= 0)
            chk($sformatf("id_stall[%0d]", i), {63'd0, id_stall}, 64'(vq[i].e_stall));
         @(posedge clk);
         #1;
         check_ex(i);
      end

      // Flush saturation: 2^16+3 flushes from a clean reset, with a pending stall request.
      rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1; flush = 1'b1; ex_ready = 1'b0;
      #1;
      chk("sat_stall_masked", {63'd0, id_stall}, 64'd0);
      for (int k = 1; k <= 65539; k++) begin
         @(posedge clk); #1;
         if (k == 65534) chk("sat_fffe", {48'd0, flush_cnt}, 64'hFFFE);
         if (k == 65535) chk("sat_ffff", {48'd0, flush_cnt}, 64'hFFFF);
      end
      chk("sat_hold", {48'd0, flush_cnt}, 64'hFFFF);
      chk("sat_bubble", {48'd0, bubble_cnt}, 64'd0);
      chk("sat_vld", {63'd0, ex_valid}, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
